pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall/flush controller for the 5-stage pipeline. Merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC and every pipeline register (`if_id`, `id_ex`, `ex_mem`, `mem_wb`). Converts an exception/redirect into a same-cycle flush with a new fetch address. Tracks stall duration for a hang watchdog and a saturating performance counter.

## Interface
- `TIMEOUT`, 256: consecutive stalled cycles that set `stall_timeout` (≥2).
- `CNT_W`, 32: width of `stall_cycles`.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `stallreq_if`  input  1  fetch wait (instruction memory not ready).
- `stallreq_id`  input  1  decode hazard (load-use).
- `stallreq_ex`  input  1  multi-cycle execute op in progress.
- `stallreq_mem`  input  1  data memory wait.
- `excp_valid`  input  1  exception/redirect taken this cycle.
- `excp_target`  input  32  redirect address.
- `cnt_clr`  input  1  synchronous clear of `stall_cycles`.
- `stall`  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush`  output  1  clear all pipeline registers on this edge.
- `new_pc`  output  32  fetch address when `flush`=1, else 0.
- `stall_timeout`  output  1  sticky watchdog flag.
- `stall_cycles`  output  CNT_W  saturating count of stalled cycles.
- `ctrl_state`  output  2  00 RUN, 01 STALL, 10 TIMEOUT.

## Operation
- Stall encoding (combinational, highest priority wins): mem → 6'b011111; ex → 6'b001111; id → 6'b000111; if → 6'b000011; none → 6'b000000. A stall request from stage k holds stages ≤ k. The stage above k advances and receives a bubble, because pipeline registers insert a bubble when stall[n]=1 and stall[n+1]=0.
- Exception wins over every stall request in the same cycle:
  - `flush`=1, `new_pc`=`excp_target`, `stall`=0.
  - Stall-length counter cleared, `stall_timeout` cleared, state → RUN.
- `any_stall` = `stall`≠0 (so 0 whenever `excp_valid`=1).
- Stall-length register `slen`, width clog2(TIMEOUT)+1:
  - Increments on each edge with `any_stall`=1; saturates at TIMEOUT.
  - Clears to 0 on each edge with `any_stall`=0.
- Watchdog: `stall_timeout` sets on the edge where `any_stall`=1 and `slen`==TIMEOUT-1, i.e. after the TIMEOUT-th consecutive stalled cycle. It remains set until a flush or reset. Dropping the stall request does not clear it.
- `stall_cycles`:
  - +1 on each edge with `any_stall`=1; saturates at all-ones.
  - `cnt_clr`=1 forces 0 on that edge and takes priority over the increment.
  - Flush does not clear it.
- FSM, evaluated each edge:
  - RUN → STALL when `any_stall`=1.
  - STALL → RUN when `any_stall`=0.
  - STALL → TIMEOUT on the edge that sets `stall_timeout`.
  - TIMEOUT → RUN when `any_stall`=0 or `excp_valid`=1.
  - Any state → RUN when `excp_valid`=1.
  - `stall` is not modified by the FSM; TIMEOUT is observation only.

## Timing
- While `rst`=0 (asynchronous): every output is 0, including the combinational `stall`, `flush`, `new_pc`. State = RUN, `slen`=0.
- Reset release: the first edge with `rst`=1 behaves as normal RUN operation.
- `stall`, `flush`, `new_pc`: zero-latency combinational from inputs, so pipeline registers act on the same edge.
- `ctrl_state`, `stall_timeout`, `stall_cycles`: reflect the edge just taken (1-cycle latency).
- Reset asserted mid-stall: counters other than `stall_cycles` restart from 0 after release. `stall_cycles` is also reset to 0.
- Simultaneous `excp_valid` and `stallreq_mem`: flush wins. `stall`=0 and the cycle is not counted.
- Simultaneous `cnt_clr` and a stalled cycle: result is 0.

## Test plan
- Priority: `stallreq_if`=`stallreq_ex`=1 → `stall`=6'b001111. Add `stallreq_mem` → 6'b011111. Release all → 6'b000000 and `ctrl_state` back to 00 one edge later.
- Flush override: `stallreq_mem`=1, `excp_valid`=1, `excp_target`=32'hBFC0_0380 in the same cycle → `flush`=1, `new_pc`=32'hBFC0_0380, `stall`=0. `stall_cycles` unchanged.
- Watchdog with TIMEOUT=16: hold `stallreq_ex` for 15 edges → `stall_timeout`=0. 16th edge → `stall_timeout`=1 and `ctrl_state`=10. Drop request → state 00, flag stays 1. Pulse `excp_valid` → flag 0.
- Counter: 5 stalled cycles, 3 free, 2 stalled → `stall_cycles`=7. `cnt_clr` during a stalled cycle → 0. With CNT_W=4 and 20 stalled cycles → holds 4'hF.
- Async reset mid-stall: `stallreq_id`=1 for 4 cycles, drop `rst` between edges → `stall` goes to 0 immediately and all outputs are 0. After release with `stallreq_id` still 1 → `stall`=6'b000111, timeout count restarts from 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Merges per-stage stall requests into a hold vector, turns an exception into a
// same-cycle flush with a redirect address, and tracks stall duration for a
// hang watchdog and a saturating stalled-cycle counter.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_target,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       ctrl_state
);

    localparam int unsigned SLEN_W = $clog2(TIMEOUT) + 1;
    localparam logic [SLEN_W-1:0] SLEN_SAT  = SLEN_W'(TIMEOUT);
    localparam logic [SLEN_W-1:0] SLEN_LAST = SLEN_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALL   = 2'b01,
        ST_TIMEOUT = 2'b10
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SLEN_W-1:0] slen;
    logic              any_stall;
    logic              timeout_hit;

    // Stall priority encoder and flush/redirect; forced quiet while in reset
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (rst) begin
            if (excp_valid) begin
                flush  = 1'b1;
                new_pc = excp_target;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    assign any_stall   = |stall;
    assign timeout_hit = any_stall && (slen == SLEN_LAST);

    // Consecutive-stall length, saturating at TIMEOUT, cleared by any free cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slen <= '0;
        end else if (!any_stall) begin
            slen <= '0;
        end else if (slen < SLEN_SAT) begin
            slen <= slen + 1'b1;
        end
    end

    // Sticky watchdog flag, only a flush (or reset) clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_timeout <= 1'b0;
        end else if (excp_valid) begin
            stall_timeout <= 1'b0;
        end else if (timeout_hit) begin
            stall_timeout <= 1'b1;
        end
    end

    // Saturating stalled-cycle counter; clear beats increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (any_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; exception returns to RUN from anywhere
    always_comb begin
        state_nxt = state;
        if (excp_valid) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (any_stall) state_nxt = ST_STALL;
                end
                ST_STALL: begin
                    if (!any_stall)       state_nxt = ST_RUN;
                    else if (timeout_hit) state_nxt = ST_TIMEOUT;
                end
                ST_TIMEOUT: begin
                    if (!any_stall) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM output: state is exposed for observation only
    always_comb begin
        ctrl_state = state;
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (TIMEOUT=16, CNT_W=4).
module tb_pipe_stall_ctrl;

    localparam int TO    = 16;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic          excp_valid;
    logic [31:0]   excp_target;
    logic          cnt_clr;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic          stall_timeout;
    logic [CW-1:0] stall_cycles;
    logic [1:0]    ctrl_state;

    int checks = 0;
    int errors = 0;

    // reference model state: length of current stall run, sticky flag, count
    int m_run  = 0;
    bit m_flag = 0;
    int m_cnt  = 0;

    pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_valid   (excp_valid),
        .excp_target  (excp_target),
        .cnt_clr      (cnt_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles (stall_cycles),
        .ctrl_state   (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          s_if, s_id, s_ex, s_mem, excp;
        logic [31:0] tgt;
        bit          clr;
        logic [5:0]  e_stall;
        bit          e_flush;
        logic [31:0] e_pc;
        logic [1:0]  e_state;
        bit          e_to;
        logic [3:0]  e_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // stall mask from the highest requesting stage: holds PC plus stages up to it
    function automatic logic [5:0] ref_stall(bit a, bit b, bit c, bit d, bit e);
        int k = -1;
        if (a) k = 0;
        if (b) k = 1;
        if (c) k = 2;
        if (d) k = 3;
        if (e || k < 0) return 6'd0;
        return 6'((1 << (k + 2)) - 1);
    endfunction

    function automatic logic [1:0] ref_state();
        if (m_run == 0) return 2'b00;
        if (m_run >= TO) return 2'b10;
        return 2'b01;
    endfunction

    task automatic model_edge(input bit stalled, input bit excp, input bit clr);
        if (excp) begin
            m_run  = 0;
            m_flag = 0;
        end else if (stalled) begin
            m_run++;
            if (m_run >= TO) m_flag = 1;
        end else begin
            m_run = 0;
        end
        if (clr) m_cnt = 0;
        else if (stalled && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic model_reset();
        m_run = 0; m_flag = 0; m_cnt = 0;
    endtask

    task automatic drive(input bit a, input bit b, input bit c, input bit d,
                         input bit e, input logic [31:0] t, input bit clr);
        stallreq_if = a; stallreq_id = b; stallreq_ex = c; stallreq_mem = d;
        excp_valid = e; excp_target = t; cnt_clr = clr;
    endtask

    // one cycle: drive, check combinational outputs, take edge, check registers
    task automatic step(input bit a, input bit b, input bit c, input bit d,
                        input bit e, input logic [31:0] t, input bit clr);
        logic [5:0] es;
        drive(a, b, c, d, e, t, clr);
        #1;
        es = ref_stall(a, b, c, d, e);
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(e));
        chk("new_pc", new_pc, e ? t : 32'd0);
        @(posedge clk);
        model_edge(es != 0, e, clr);
        #1;
        chk("ctrl_state", 32'(ctrl_state), 32'(ref_state()));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_flag));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    endtask

    task automatic stall_n(input int n, input bit a, input bit b, input bit c, input bit d);
        for (int i = 0; i < n; i++) step(a, b, c, d, 0, 32'd0, 0);
    endtask

    initial begin
        int burst;
        //          if id ex mem ex  target         clr  stall      fl pc             st    to cyc
        vecs[0] = '{1, 0, 1, 0, 0, 32'd0,          0, 6'b001111, 0, 32'd0,         2'b01, 0, 4'd1};
        vecs[1] = '{1, 0, 1, 1, 0, 32'd0,          0, 6'b011111, 0, 32'd0,         2'b01, 0, 4'd2};
        vecs[2] = '{0, 0, 0, 0, 0, 32'd0,          0, 6'b000000, 0, 32'd0,         2'b00, 0, 4'd2};
        vecs[3] = '{0, 0, 0, 1, 1, 32'hBFC0_0380,  0, 6'b000000, 1, 32'hBFC0_0380, 2'b00, 0, 4'd2};
        vecs[4] = '{0, 1, 0, 0, 0, 32'd0,          0, 6'b000111, 0, 32'd0,         2'b01, 0, 4'd3};
        vecs[5] = '{0, 1, 0, 0, 0, 32'd0,          1, 6'b000111, 0, 32'd0,         2'b01, 0, 4'd0};
        vecs[6] = '{1, 0, 0, 0, 0, 32'd0,          0, 6'b000011, 0, 32'd0,         2'b01, 0, 4'd1};
        vecs[7] = '{0, 0, 0, 0, 0, 32'd0,          1, 6'b000000, 0, 32'd0,         2'b00, 0, 4'd0};

        // reset with requests active: everything must read zero
        rst = 1'b0;
        drive(0, 0, 1, 1, 1, 32'hDEAD_BEEF, 0);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_timeout", 32'(stall_timeout), 32'd0);
        chk("rst_cycles", 32'(stall_cycles), 32'd0);
        drive(0, 0, 0, 0, 0, 32'd0, 0);
        #11;
        rst = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].s_if, vecs[i].s_id, vecs[i].s_ex, vecs[i].s_mem,
                  vecs[i].excp, vecs[i].tgt, vecs[i].clr);
            #1;
            chk("tbl_stall", 32'(stall), 32'(vecs[i].e_stall));
            chk("tbl_flush", 32'(flush), 32'(vecs[i].e_flush));
            chk("tbl_new_pc", new_pc, vecs[i].e_pc);
            @(posedge clk);
            model_edge(vecs[i].e_stall != 0, vecs[i].excp, vecs[i].clr);
            #1;
            chk("tbl_state", 32'(ctrl_state), 32'(vecs[i].e_state));
            chk("tbl_timeout", 32'(stall_timeout), 32'(vecs[i].e_to));
            chk("tbl_cycles", 32'(stall_cycles), 32'(vecs[i].e_cyc));
        end

        // counter: 5 stalled, 3 free, 2 stalled -> 7
        stall_n(5, 1, 0, 0, 0);
        stall_n(3, 0, 0, 0, 0);
        stall_n(2, 1, 0, 0, 0);
        chk("cnt_seven", 32'(stall_cycles), 32'd7);
        step(0, 0, 1, 0, 0, 32'd0, 1);
        chk("cnt_clr_stalled", 32'(stall_cycles), 32'd0);
        stall_n(20, 0, 0, 1, 0);
        chk("cnt_saturate", 32'(stall_cycles), 32'hF);
        step(0, 0, 0, 0, 1, 32'h0000_0100, 0);
        chk("cnt_kept_by_flush", 32'(stall_cycles), 32'hF);
        step(0, 0, 0, 0, 0, 32'd0, 1);

        // watchdog
        stall_n(15, 0, 0, 1, 0);
        chk("wd_15_clear", 32'(stall_timeout), 32'd0);
        chk("wd_15_state", 32'(ctrl_state), 32'b01);
        stall_n(1, 0, 0, 1, 0);
        chk("wd_16_set", 32'(stall_timeout), 32'd1);
        chk("wd_16_state", 32'(ctrl_state), 32'b10);
        stall_n(1, 0, 0, 0, 0);
        chk("wd_drop_state", 32'(ctrl_state), 32'b00);
        chk("wd_drop_sticky", 32'(stall_timeout), 32'd1);
        step(0, 0, 0, 0, 1, 32'h8000_0000, 0);
        chk("wd_flush_clear", 32'(stall_timeout), 32'd0);

        // async reset mid-stall
        stall_n(4, 0, 1, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_new_pc", new_pc, 32'd0);
        chk("arst_state", 32'(ctrl_state), 32'd0);
        chk("arst_timeout", 32'(stall_timeout), 32'd0);
        chk("arst_cycles", 32'(stall_cycles), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_release_stall", 32'(stall), 32'b000111);
        stall_n(15, 0, 1, 0, 0);
        chk("arst_restart_to", 32'(stall_timeout), 32'd0);
        stall_n(1, 0, 1, 0, 0);
        chk("arst_restart_set", 32'(stall_timeout), 32'd1);
        step(0, 0, 0, 0, 1, 32'd4, 0);

        // randomized traffic against the model, with occasional long stalls
        burst = 0;
        for (int i = 0; i < 600; i++) begin
            bit a, b, c, d, e, clr;
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(10, 25);
            a = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 4) == 0);
            if (burst > 0) begin
                c = 1;
                burst--;
            end
            e   = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 19) == 0);
            step(a, b, c, d, e, $urandom, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
